times_table_arbiter: RTL and testbench

//   Shares one times_table multiplier (3b x 3b -> 6b, registered, gated by enable)

---
 rtl/times_table_arbiter_if.sv | 54 +++++
 rtl/times_table_arbiter.sv | 171 +++++++++++++++++
 tb/tb_times_table_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/times_table_arbiter_if.sv
// ---------------------------------------------------------------------------
// times_table_arbiter_if
//   Bundles the request, response and multiplier-side signals of the
//   two-requester times_table arbiter.
//
//   slave  : the arbiter. It consumes the requests and mul_result, and
//            drives the ready, response and multiplier-control signals.
//   master : the environment (both clients and the times_table multiplier).
//
//   Signals
//     req0_valid/req0_a/req0_b  requester 0 operation (a, b are 3-bit)
//     req0_ready                requester 0 accepted this cycle
//     req1_valid/req1_a/req1_b  requester 1 operation
//     req1_ready                requester 1 accepted this cycle
//     rsp0_valid/rsp1_valid     one-cycle response pulse per owner
//     rsp_result                registered 6-bit product
//     mul_a/mul_b/mul_enable    drive to times_table
//     mul_result                product returned by times_table
// ---------------------------------------------------------------------------
interface times_table_arbiter_if;
  logic       req0_valid;
  logic [2:0] req0_a;
  logic [2:0] req0_b;
  logic       req0_ready;
  logic       req1_valid;
  logic [2:0] req1_a;
  logic [2:0] req1_b;
  logic       req1_ready;
  logic       rsp0_valid;
  logic       rsp1_valid;
  logic [5:0] rsp_result;
  logic [2:0] mul_a;
  logic [2:0] mul_b;
  logic       mul_enable;
  logic [5:0] mul_result;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  mul_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result,
    output mul_a, mul_b, mul_enable
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output mul_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result,
    input  mul_a, mul_b, mul_enable
  );
endinterface

// File: rtl/times_table_arbiter.sv
// ---------------------------------------------------------------------------
// times_table_arbiter
//   Shares one registered times_table multiplier (3b x 3b -> 6b) between two
//   requesters. Uses round-robin arbitration, a valid/ready request handshake
//   and a one-cycle response pulse to the owner of each operation.
//
//   Ports
//     clk     system clock, rising edge
//     rst_n   asynchronous active-low reset
//     bus     times_table_arbiter_if.slave (requests, responses, multiplier)
//     gnt0_count, gnt1_count  (only with TT_ARB_STATS_EN) saturating 8-bit
//             accept counters per requester
//
//   Parameters
//     LATENCY  clock edges from mul_enable/operands stable to mul_result valid
//              (>= 1)
//
//   Configuration macro: TT_ARB_STATS_EN adds the grant counters.
//
//   Sequence: IDLE -> BUSY (LATENCY+1 cycles) -> RESP (1 cycle) -> IDLE.
// ---------------------------------------------------------------------------
module times_table_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  times_table_arbiter_if.slave bus
`ifdef TT_ARB_STATS_EN
  ,
  output logic [7:0]           gnt0_count,
  output logic [7:0]           gnt1_count
`endif
);

  if (LATENCY < 1) begin : g_latency_check
    $error("times_table_arbiter: LATENCY must be >= 1");
  end

  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          ptr;      // 1: requester 1 wins a tie
  logic          owner;    // requester of the operation in flight
  logic [2:0]    op_a;
  logic [2:0]    op_b;
  logic [CW-1:0] cnt;
  logic [5:0]    result;

  logic          win0;
  logic          win1;
  logic          accept0;
  logic          accept1;
  logic          accept;
  logic          done;

  // A sole valid requester wins outright; a tie goes to the pointer.
  assign win0    = bus.req0_valid & (~bus.req1_valid | ~ptr);
  assign win1    = bus.req1_valid & (~bus.req0_valid |  ptr);
  assign accept0 = (state == IDLE) & win0;
  assign accept1 = (state == IDLE) & win1;
  assign accept  = accept0 | accept1;
  assign done    = (state == BUSY) && (cnt == '0);

  // State register.
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update together from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: each combinational block assigns a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (done)   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic. The multiplier sees zero operands and no enable outside
  // BUSY, so it only toggles while an operation is in flight.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.mul_a      = 3'd0;
    bus.mul_b      = 3'd0;
    bus.mul_enable = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req0_ready = accept0;
        bus.req1_ready = accept1;
      end
      BUSY: begin
        bus.mul_enable = 1'b1;
        bus.mul_a      = op_a;
        bus.mul_b      = op_b;
      end
      RESP: begin
        bus.rsp0_valid = ~owner;
        bus.rsp1_valid =  owner;
      end
      default: ;
    endcase
  end

  assign bus.rsp_result = result;

  // Control datapath: owner, round-robin pointer, latency counter, result.
  // The pointer moves away from whoever was just granted, even if that
  // requester was the only one asking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      cnt    <= '0;
      result <= 6'd0;
    end else begin
      if (accept) begin
        owner <= accept1;
        ptr   <= accept0;
        cnt   <= CW'(LATENCY);
      end else if (state == BUSY) begin
        if (done) begin
          result <= bus.mul_result;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  // NOTE: the operand registers are not reset; they are loaded on every
  // accept and only reach the outputs during BUSY, after that load.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= accept1 ? bus.req1_a : bus.req0_a;
      op_b <= accept1 ? bus.req1_b : bus.req0_b;
    end
  end

`ifdef TT_ARB_STATS_EN
  // Per-requester accept counters, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_count <= 8'd0;
      gnt1_count <= 8'd0;
    end else begin
      if (accept0 && (gnt0_count != 8'hFF)) gnt0_count <= gnt0_count + 8'd1;
      if (accept1 && (gnt1_count != 8'hFF)) gnt1_count <= gnt1_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_times_table_arbiter.sv
// ---------------------------------------------------------------------------
// tb_times_table_arbiter
//   Self-checking bench for times_table_arbiter. It holds a times_table
//   model, a transaction-level reference model of the arbiter that is checked
//   every cycle, directed cases with literal expectations, and a randomized
//   phase.
// ---------------------------------------------------------------------------
module tb_times_table_arbiter;

  localparam int LAT = 1;

  logic clk;
  logic rst_n;

  times_table_arbiter_if bus ();

`ifdef TT_ARB_STATS_EN
  logic [7:0] gnt0_count;
  logic [7:0] gnt1_count;
  times_table_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .gnt0_count(gnt0_count), .gnt1_count(gnt1_count)
  );
`else
  times_table_arbiter #(.LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- client drive ----------------
  logic       v   [2];
  logic [2:0] ra  [2];
  logic [2:0] rb  [2];
  logic       rdy_s [2];
  logic [5:0] q0[$];
  logic [5:0] q1[$];
  int         gate_pct;
  bit         drop_en;

  assign bus.req0_valid = v[0];
  assign bus.req0_a     = ra[0];
  assign bus.req0_b     = rb[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_a     = ra[1];
  assign bus.req1_b     = rb[1];

  // ---------------- times_table model ----------------
  logic [5:0] mstage [LAT];
  assign bus.mul_result = mstage[LAT-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) mstage[i] <= 6'd0;
    end else if (bus.mul_enable) begin
      mstage[0] <= 6'(bus.mul_a) * 6'(bus.mul_b);
      for (int i = 1; i < LAT; i++) mstage[i] <= mstage[i-1];
    end
  end

  // ---------------- reference model ----------------
  // m_k counts cycles since the accept edge: 0 = idle, 1..LAT+1 = multiplier
  // in use, LAT+2 = response cycle.
  int         m_k;
  bit         m_ptr;
  bit         m_owner;
  logic [2:0] m_a;
  logic [2:0] m_b;
  logic [5:0] m_res;
  int         cyc;

  always @(posedge clk) cyc++;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = 0; m_ptr = 0; m_owner = 0; m_res = 0; m_a = 0; m_b = 0;
    end else begin
      if (m_k == 0) begin
        bit w0, w1;
        w0 = v[0] && (!v[1] || !m_ptr);
        w1 = v[1] && (!v[0] ||  m_ptr);
        if (w0 || w1) begin
          m_owner = w1;
          m_a     = w1 ? ra[1] : ra[0];
          m_b     = w1 ? rb[1] : rb[0];
          m_ptr   = w0;
          m_k     = 1;
        end
      end else if (m_k == LAT + 1) begin
        m_res = 6'(m_a) * 6'(m_b);
        m_k   = LAT + 2;
      end else if (m_k == LAT + 2) begin
        m_k = 0;
      end else begin
        m_k++;
      end
    end
  end

  // ---------------- checking ----------------
  int n_checks;
  int n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Logs written by the compare process and read by the directed tests.
  int g_id[$];
  int g_cyc[$];
  int r_id[$];
  int r_res[$];
  int r_cyc[$];
  int both_ready;

  always @(negedge clk) begin
    bit e_r0, e_r1, e_en, e_s0, e_s1;
    logic [2:0] e_a, e_b;
    e_r0 = 0; e_r1 = 0; e_en = 0; e_s0 = 0; e_s1 = 0; e_a = 0; e_b = 0;
    if (m_k == 0) begin
      e_r0 = v[0] && (!v[1] || !m_ptr);
      e_r1 = v[1] && (!v[0] ||  m_ptr);
    end else if (m_k <= LAT + 1) begin
      e_en = 1; e_a = m_a; e_b = m_b;
    end else begin
      e_s0 = !m_owner; e_s1 = m_owner;
    end
    check("req0_ready", bus.req0_ready, e_r0);
    check("req1_ready", bus.req1_ready, e_r1);
    check("mul_enable", bus.mul_enable, e_en);
    check("mul_a", bus.mul_a, e_a);
    check("mul_b", bus.mul_b, e_b);
    check("rsp0_valid", bus.rsp0_valid, e_s0);
    check("rsp1_valid", bus.rsp1_valid, e_s1);
    check("rsp_result", bus.rsp_result, m_res);

    rdy_s[0] = bus.req0_ready;
    rdy_s[1] = bus.req1_ready;
    if (bus.req0_ready && bus.req1_ready) both_ready++;
    if (v[0] && bus.req0_ready) begin g_id.push_back(0); g_cyc.push_back(cyc); end
    if (v[1] && bus.req1_ready) begin g_id.push_back(1); g_cyc.push_back(cyc); end
    if (bus.rsp0_valid) begin r_id.push_back(0); r_res.push_back(bus.rsp_result); r_cyc.push_back(cyc); end
    if (bus.rsp1_valid) begin r_id.push_back(1); r_res.push_back(bus.rsp_result); r_cyc.push_back(cyc); end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    for (int ch = 0; ch < 2; ch++) begin
      logic [5:0] op;
      if (v[ch] && rdy_s[ch]) begin
        v[ch] = 1'b0;                       // accepted at the last edge
      end else if (v[ch] && drop_en && ($urandom_range(15) == 0)) begin
        v[ch] = 1'b0;                       // withdraw, retry later
        if (ch == 0) q0.push_front({ra[0], rb[0]});
        else         q1.push_front({ra[1], rb[1]});
      end
      if (!v[ch] && ($urandom_range(99) < gate_pct)) begin
        if (ch == 0 && q0.size() != 0) begin
          op = q0.pop_front(); v[0] = 1'b1; ra[0] = op[5:3]; rb[0] = op[2:0];
        end else if (ch == 1 && q1.size() != 0) begin
          op = q1.pop_front(); v[1] = 1'b1; ra[1] = op[5:3]; rb[1] = op[2:0];
        end
      end
    end
  endtask

  task automatic run_until(input int n_rsp, input int budget, input string name);
    int n;
    n = 0;
    while (r_id.size() < n_rsp && n < budget) begin
      tick();
      n++;
    end
    check({name, "_timeout"}, (r_id.size() >= n_rsp), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v[0] = 0; v[1] = 0;
    q0.delete(); q1.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int base;
    int gb;
    int n;
    int n_ops;
    n_checks = 0; n_fail = 0; both_ready = 0;
    gate_pct = 100; drop_en = 0;
    v[0] = 0; v[1] = 0; ra[0] = 0; ra[1] = 0; rb[0] = 0; rb[1] = 0;
    rdy_s[0] = 0; rdy_s[1] = 0;
    rst_n = 1'b0;
    #1;
    check("reset_rsp_result", bus.rsp_result, 0);
    check("reset_mul_enable", bus.mul_enable, 0);
    check("reset_ready", {bus.req0_ready, bus.req1_ready}, 0);
    check("reset_rsp", {bus.rsp0_valid, bus.rsp1_valid}, 0);
    do_reset();

    // 1: req0 alone, 3*5
    base = r_id.size(); gb = g_id.size();
    q0.push_back({3'd3, 3'd5});
    run_until(base + 1, 20, "t1");
    check("t1_grants", g_id.size() - gb, 1);
    check("t1_owner", r_id[base], 0);
    check("t1_result", r_res[base], 15);
    check("t1_latency", r_cyc[base] - g_cyc[gb], LAT + 2);

    // 2: both valid together from reset
    do_reset();
    base = r_id.size(); gb = g_id.size();
    q0.push_back({3'd2, 3'd3});
    q1.push_back({3'd4, 3'd4});
    run_until(base + 2, 40, "t2");
    check("t2_first", g_id[gb], 0);
    check("t2_second", g_id[gb+1], 1);
    check("t2_res0", r_res[base], 6);
    check("t2_res1", r_res[base+1], 16);
    check("t2_both_ready", both_ready, 0);

    // 3: continuous contention, alternating grants
    base = r_id.size(); gb = g_id.size();
    q0.push_back({3'd1, 3'd2}); q0.push_back({3'd3, 3'd3});
    q1.push_back({3'd2, 3'd5}); q1.push_back({3'd6, 3'd7});
    run_until(base + 4, 60, "t3");
    check("t3_order", {g_id[gb][0], g_id[gb+1][0], g_id[gb+2][0], g_id[gb+3][0]}, 4'b0101);
    check("t3_res_a", r_res[base],   2);
    check("t3_res_b", r_res[base+1], 10);
    check("t3_res_c", r_res[base+2], 9);
    check("t3_res_d", r_res[base+3], 42);

    // 4: corners
    base = r_id.size();
    q0.push_back({3'd7, 3'd7});
    q1.push_back({3'd0, 3'd6});
    run_until(base + 2, 40, "t4");
    check("t4_49", r_res[base], 49);
    check("t4_0", r_res[base+1], 0);

    // 5: reset while busy
    q0.push_back({3'd5, 3'd5});
    n = 0;
    while (!bus.mul_enable && n < 20) begin tick(); n++; end
    check("t5_reached_busy", bus.mul_enable, 1);
    rst_n = 1'b0;
    v[0] = 0; v[1] = 0;
    q0.delete(); q1.delete();
    #1;
    check("t5_mul_enable", bus.mul_enable, 0);
    check("t5_mul_ab", {bus.mul_a, bus.mul_b}, 0);
    check("t5_result", bus.rsp_result, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    base = r_id.size();
    repeat (10) tick();
    check("t5_no_pulse", r_id.size() - base, 0);
    gb = g_id.size();
    q0.push_back({3'd6, 3'd3});
    q1.push_back({3'd1, 3'd1});
    run_until(base + 2, 40, "t5");
    check("t5_first_gnt", g_id[gb], 0);
    check("t5_res", r_res[base], 18);

    // Random phase
    gate_pct = 60; drop_en = 1;
    n_ops = 200;
    base = r_id.size();
    for (int i = 0; i < n_ops; i++) begin
      logic [5:0] op;
      op = 6'($urandom);
      if ($urandom_range(1) == 0) q0.push_back(op);
      else                        q1.push_back(op);
    end
    run_until(base + n_ops, 5000, "rand");
    check("rand_count", r_id.size() - base, n_ops);
    drop_en = 0;
    repeat (5) tick();

`ifdef TT_ARB_STATS_EN
    // 6: grant counter saturation
    gate_pct = 100;
    do_reset();
    base = r_id.size();
    for (int i = 0; i < 300; i++) q1.push_back(6'($urandom));
    run_until(base + 300, 3000, "t6");
    check("t6_gnt1", gnt1_count, 255);
    check("t6_gnt0", gnt0_count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
